debounce_edge: RTL and testbench



---
 rtl/debounce_edge_if.sv | 23 ++
 rtl/debounce_edge.sv | 133 +++++++++++++
 tb/tb_debounce_edge.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/debounce_edge_if.sv
// Signal bundle between the debouncer and its consumer.
// The master drives the raw input and clear; the slave returns the conditioned level, pulses and count.
interface debounce_edge_if #(
  parameter int CNT_W = 8
);
  logic             d;
  logic             clr;
  logic             q;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] rise_count;
  logic [1:0]       dbg_state;

  modport master (
    output d, clr,
    input  q, rise, fall, rise_count, dbg_state
  );

  modport slave (
    input  d, clr,
    output q, rise, fall, rise_count, dbg_state
  );
endinterface

// File: rtl/debounce_edge.sv
// Two-flop synchronizer followed by a four-state debounce FSM with a stability counter.
// Produces a clean level, registered one-cycle rise/fall pulses and a saturating rise count.
module debounce_edge #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input logic            clk,
  input logic            rst_n,
  debounce_edge_if.slave bus
);

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } state_t;

  localparam int              CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1, s2;
  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             rise_r, fall_r, rise_nx, fall_nx;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bus.d;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= LOW;
      cnt    <= '0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      rise_r <= rise_nx;
      fall_r <= fall_nx;
    end
  end

  // A check state leaves on the first opposite sample, so cnt counts an unbroken run.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    case (state)
      LOW: begin
        if (s2) begin
          if (STABLE_CYCLES == 1) begin
            state_nx = HIGH;
            rise_nx  = 1'b1;
            cnt_nx   = '0;
          end else begin
            state_nx = RISE_CHK;
            cnt_nx   = CNT_ONE;
          end
        end
      end
      RISE_CHK: begin
        if (!s2) begin
          state_nx = LOW;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = HIGH;
          rise_nx  = 1'b1;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s2) begin
          if (STABLE_CYCLES == 1) begin
            state_nx = LOW;
            fall_nx  = 1'b1;
            cnt_nx   = '0;
          end else begin
            state_nx = FALL_CHK;
            cnt_nx   = CNT_ONE;
          end
        end
      end
      FALL_CHK: begin
        if (s2) begin
          state_nx = HIGH;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = LOW;
          fall_nx  = 1'b1;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nx = LOW;
        cnt_nx   = '0;
      end
    endcase
  end

  // Clear takes priority over a rise landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (bus.clr) begin
      count <= '0;
    end else if (rise_nx && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

  assign bus.q          = (state == HIGH) || (state == FALL_CHK);
  assign bus.rise       = rise_r;
  assign bus.fall       = fall_r;
  assign bus.rise_count = count;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge: default instance plus a CNT_W=2 instance sharing the stimulus.
// Pulse events are queued when stimulus is driven and matched when the DUTs pulse.
module tb_debounce_edge;

  localparam int STABLE = 4;
  localparam int W      = 32;

  logic clk;
  logic rst_n;
  int   edge_n;
  int   total;
  int   bad;

  logic [W-1:0] exp_q[$];
  logic [7:0]   ca;
  logic [1:0]   cb;
  logic         lvl;
  logic         mon_q;

  debounce_edge_if #(.CNT_W(8)) bus_a ();
  debounce_edge_if #(.CNT_W(2)) bus_b ();

  debounce_edge #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  debounce_edge #(.STABLE_CYCLES(STABLE), .CNT_W(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // event layout: {pad, rise, fall, edge[15:0], count_a[7:0], count_b[1:0], q}
  function automatic logic [W-1:0] pack(input logic r, input logic f, input int e,
                                        input logic [7:0] xa, input logic [1:0] xb,
                                        input logic qq);
    logic [15:0] e16;
    e16 = e[15:0];
    return {3'b000, r, f, e16, xa, xb, qq};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_d(input logic val);
    bus_a.d = val;
    bus_b.d = val;
  endtask

  task automatic set_clr(input logic val);
    bus_a.clr = val;
    bus_b.clr = val;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Called at a falling edge; the first rising edge that samples val is edge_n+1.
  task automatic hold(input logic val, input int n, input bit clr_ev);
    int ev;
    ev = edge_n + 1 + 1 + STABLE;
    set_d(val);
    if ((val != lvl) && (n >= STABLE)) begin
      lvl = val;
      if (val) begin
        ca = (ca == 8'hff) ? ca : ca + 8'd1;
        cb = (cb == 2'd3) ? cb : cb + 2'd1;
        if (clr_ev) begin
          ca = 8'd0;
          cb = 2'd0;
        end
      end
      exp_q.push_back(pack(val, !val, ev, ca, cb, val));
    end
    for (int i = 0; i < n; i++) begin
      set_clr(clr_ev && (edge_n + 1 == ev));
      @(negedge clk);
    end
    set_clr(1'b0);
  endtask

  // scoreboard monitor, sampled 1 time unit after each rising edge
  always @(posedge clk) begin
    logic [W-1:0] exp;
    #1;
    if (bus_a.rise || bus_a.fall) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_pulse edge=%0d rise=%b fall=%b", edge_n, bus_a.rise, bus_a.fall);
      end
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        check("pulse_a", pack(bus_a.rise, bus_a.fall, edge_n, bus_a.rise_count,
                              bus_b.rise_count, bus_a.q), exp);
        check("pulse_b", pack(bus_b.rise, bus_b.fall, edge_n, bus_a.rise_count,
                              bus_b.rise_count, bus_b.q), exp);
        mon_q = exp[0];
      end
    end else begin
      if (exp_q.size() != 0) begin
        total++;
        assert (exp_q[0][26:11] != edge_n[15:0]) else begin
          bad++;
          $error("FAIL missed_pulse edge=%0d expected=%h", edge_n, exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
      check("idle_levels", {28'd0, bus_a.q, bus_b.q, bus_b.rise, bus_b.fall},
            {28'd0, mon_q, mon_q, 2'b00});
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    ca    = 8'd0;
    cb    = 2'd0;
    lvl   = 1'b0;
    mon_q = 1'b0;
    rst_n = 1'b0;
    set_d(1'b0);
    set_clr(1'b0);
    idle(2);

    check("reset_a", {19'd0, bus_a.q, bus_a.rise, bus_a.fall, bus_a.rise_count, bus_a.dbg_state},
          32'd0);
    check("reset_b", {25'd0, bus_b.q, bus_b.rise, bus_b.fall, bus_b.rise_count, bus_b.dbg_state},
          32'd0);
    rst_n = 1'b1;

    // 1: clean rise after full latency, then return low
    hold(1'b1, 8, 1'b0);
    hold(1'b0, 8, 1'b0);

    // 2: two-cycle glitch is rejected
    hold(1'b1, 2, 1'b0);
    hold(1'b0, 8, 1'b0);
    check("glitch_q_cnt", {23'd0, bus_a.q, bus_a.rise_count}, {23'd0, 1'b0, ca});

    // 3: six-cycle high then six-cycle low
    hold(1'b1, 6, 1'b0);
    hold(1'b0, 6, 1'b0);
    idle(2);

    // 4: bounce then settle high
    hold(1'b1, 1, 1'b0);
    hold(1'b0, 1, 1'b0);
    hold(1'b1, 1, 1'b0);
    hold(1'b0, 1, 1'b0);
    hold(1'b1, 1, 1'b0);
    hold(1'b0, 1, 1'b0);
    hold(1'b1, 10, 1'b0);
    hold(1'b0, 8, 1'b0);
    check("bounce_cnt", {24'd0, bus_a.rise_count}, {24'd0, ca});

    // 5: reset in the middle of a rise check
    set_d(1'b1);
    idle(3);
    check("midcheck_state", {30'd0, bus_a.dbg_state}, {30'd0, 2'd1});
    rst_n = 1'b0;
    #1;
    check("midreset_a", {19'd0, bus_a.q, bus_a.rise, bus_a.fall, bus_a.rise_count, bus_a.dbg_state},
          32'd0);
    check("midreset_b", {25'd0, bus_b.q, bus_b.rise, bus_b.fall, bus_b.rise_count, bus_b.dbg_state},
          32'd0);
    #2;
    rst_n = 1'b1;
    mon_q = 1'b0;
    ca    = 8'd1;
    cb    = 2'd1;
    lvl   = 1'b1;
    exp_q.push_back(pack(1'b1, 1'b0, edge_n + 1 + 1 + STABLE, ca, cb, 1'b1));
    idle(8);
    hold(1'b0, 8, 1'b0);

    // 6: saturation of the narrow counter, then clear coinciding with a rise
    for (int i = 0; i < 4; i++) begin
      hold(1'b1, 6, 1'b0);
      hold(1'b0, 6, 1'b0);
    end
    check("sat_cnt_b", {30'd0, bus_b.rise_count}, {30'd0, 2'd3});
    check("sat_cnt_a", {24'd0, bus_a.rise_count}, {24'd0, 8'd5});
    hold(1'b1, 8, 1'b1);
    check("clr_cnt", {22'd0, bus_a.rise_count, bus_b.rise_count}, 32'd0);
    hold(1'b0, 8, 1'b0);

    idle(4);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
